// File: rtl/prog_timer_pkg.sv
// Shared types and default sizing for the programmable timer bank.
package prog_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

endpackage

// File: rtl/prog_timer_ch.sv
// One timer channel: IDLE/RUN FSM counting 0..term_q, pulsing done at terminal count.
module prog_timer_ch
    import prog_timer_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_mode,
    input  logic [W-1:0] i_term,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_count,
    output logic         o_done_nxt
);

    state_e       r_state;
    state_e       w_state_nxt;
    mode_e        r_mode;
    mode_e        w_mode_nxt;
    logic [W-1:0] r_term;
    logic [W-1:0] w_term_nxt;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         r_done;
    logic         w_done_nxt;
    logic         w_at_term;

    assign w_at_term = (r_count == r_term);

    // Channel state register; reset wins over every request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= ONE_SHOT;
            r_term  <= {W{1'b0}};
            r_count <= {W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_term  <= w_term_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic; stop outranks start, restart suppresses a terminal-count done
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_term_nxt  = r_term;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt = RUN;
                    w_mode_nxt  = mode_e'(i_mode);
                    w_term_nxt  = i_term;
                    w_count_nxt = {W{1'b0}};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt = IDLE;
                end else if (i_start) begin
                    w_mode_nxt  = mode_e'(i_mode);
                    w_term_nxt  = i_term;
                    w_count_nxt = {W{1'b0}};
                end else if (w_at_term) begin
                    w_done_nxt = 1'b1;
                    if (r_mode == PERIODIC) begin
                        w_count_nxt = {W{1'b0}};
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_count_nxt = r_count + {{(W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state == RUN);
    assign o_done     = r_done;
    assign o_count    = r_count;
    assign o_done_nxt = w_done_nxt;

endmodule

// File: rtl/prog_timer_bank.sv
// Bank of NCH independent programmable timers with a combined, done-aligned any_done flag.
module prog_timer_bank
    import prog_timer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        start,
    input  logic [NCH-1:0]        stop,
    input  logic [NCH-1:0]        mode,
    input  logic [NCH-1:0][W-1:0] term,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0][W-1:0] count,
    output logic                  any_done
);

    logic [NCH-1:0] w_done_nxt;
    logic           r_any_done;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        prog_timer_ch #(
            .W (W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_start    (start[g]),
            .i_stop     (stop[g]),
            .i_mode     (mode[g]),
            .i_term     (term[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g]),
            .o_count    (count[g]),
            .o_done_nxt (w_done_nxt[g])
        );
    end

    // OR of next-cycle done terms, so any_done lands on the same cycle as done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_done <= 1'b0;
        end else begin
            r_any_done <= |w_done_nxt;
        end
    end

    assign any_done = r_any_done;

endmodule
